// File: rtl/regfile_pkg.sv
// Shared defaults and FSM state type for the vector register file.
package regfile_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int LANES_DEF  = 4;
  localparam int NREGS_DEF  = 16;
  localparam int NREAD_DEF  = 3;
  localparam int BYPASS_DEF = 1;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

endpackage

// File: rtl/reg_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, bit 0 hard-wired low.
module reg_scoreboard
  import regfile_pkg::*;
#(
  parameter  int NREGS = NREGS_DEF,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             set_en,
  input  logic [AW-1:0]    set_addr,
  input  logic             clr_en,
  input  logic [AW-1:0]    clr_addr,
  input  logic             clr_all,
  output logic [NREGS-1:0] busy_vec
);

  logic [NREGS-1:0] busy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= '0;
    end else if (clr_all) begin
      busy <= '0;
    end else begin
      // NOTE: non-blocking assignments to the same bit resolve to the last one
      // written, so placing the set after the clear makes a reserve win.
      if (clr_en) busy[clr_addr] <= 1'b0;
      if (set_en) busy[set_addr] <= 1'b1;
      busy[0] <= 1'b0;
    end
  end

  assign busy_vec = busy;

endmodule

// File: rtl/register_vector.sv
// Multi-port vector register file with lane-masked writes, write-to-read
// forwarding, a reservation scoreboard and a sequential bulk-clear engine.
module register_vector
  import regfile_pkg::*;
#(
  parameter  int DATA_W = DATA_W_DEF,
  parameter  int LANES  = LANES_DEF,
  parameter  int NREGS  = NREGS_DEF,
  parameter  int NREAD  = NREAD_DEF,
  parameter  int BYPASS = BYPASS_DEF,
  localparam int AW     = $clog2(NREGS)
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic [NREAD-1:0][AW-1:0]                rs_addr,
  output logic [NREAD-1:0][LANES-1:0][DATA_W-1:0] rd_data,
  input  logic                                    wr_en,
  input  logic [AW-1:0]                           wr_addr,
  input  logic [LANES-1:0][DATA_W-1:0]            wr_data,
  input  logic [LANES-1:0]                        wr_mask,
  input  logic                                    rsv_en,
  input  logic [AW-1:0]                           rsv_addr,
  output logic [NREGS-1:0]                        busy_vec,
  input  logic                                    clr_req,
  output logic                                    clr_busy
);

  localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);

  state_t                         state;
  logic [AW-1:0]                  cnt;
  logic [LANES-1:0][DATA_W-1:0]   regs [NREGS];

  logic wr_commit;
  logic sb_set;
  logic clr_start;

  // A write only lands in IDLE, to a real register, touching at least one lane.
  assign wr_commit = (state == IDLE) && wr_en && (wr_addr != '0) && (|wr_mask);
  assign sb_set    = (state == IDLE) && rsv_en && (rsv_addr != '0);
  assign clr_start = (state == IDLE) && clr_req;
  assign clr_busy  = (state == CLEAR);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      // NOTE: the storage array is reset explicitly because reset must leave
      // every register reading zero; this keeps it in flops rather than a RAM.
      for (int r = 0; r < NREGS; r++) regs[r] <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (wr_commit) begin
            for (int l = 0; l < LANES; l++)
              if (wr_mask[l]) regs[wr_addr][l] <= wr_data[l];
          end
          if (clr_req) begin
            state <= CLEAR;
            cnt   <= AW'(1);
          end
        end
        CLEAR: begin
          regs[cnt] <= '0;
          cnt       <= cnt + AW'(1);
          if (cnt == LAST_IDX) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    for (int p = 0; p < NREAD; p++) begin
      // NOTE: each port is fully assigned before any override so no latch forms.
      rd_data[p] = regs[rs_addr[p]];
      if (rs_addr[p] == '0) begin
        rd_data[p] = '0;
      end else if ((BYPASS != 0) && wr_commit && (rs_addr[p] == wr_addr)) begin
        for (int l = 0; l < LANES; l++)
          if (wr_mask[l]) rd_data[p][l] = wr_data[l];
      end
    end
  end

  reg_scoreboard #(
    .NREGS (NREGS)
  ) u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .set_en   (sb_set),
    .set_addr (rsv_addr),
    .clr_en   (wr_commit),
    .clr_addr (wr_addr),
    .clr_all  (clr_start),
    .busy_vec (busy_vec)
  );

endmodule

// File: doc/register_vector.md
REGISTER_VECTOR -- requirements
Module: register_vector

Interface
REQ-001 Parameter: DATA_W, 32, lane width in bits.
REQ-002 Parameter: LANES, 4, lanes per register.
REQ-003 Parameter: NREGS, 16, register count (power of two, >=4); AW = log2(NREGS).
REQ-004 Parameter: NREAD, 3, number of read ports.
REQ-005 Parameter: BYPASS, 1, write-to-read forwarding (1 = on, 0 = off).
REQ-006 clk  in  1  clock; all state updates on the rising edge.
REQ-007 rst  in  1  reset, asynchronous, active-high.
REQ-008 rs_addr  in  NREAD x AW  read-port addresses.
REQ-009 rd_data  out  NREAD x LANES x DATA_W  read-port data.
REQ-010 wr_en  in  1  write request.
REQ-011 wr_addr  in  AW  write address.
REQ-012 wr_data  in  LANES x DATA_W  write data.
REQ-013 wr_mask  in  LANES  per-lane write enable.
REQ-014 rsv_en  in  1  scoreboard reserve request.
REQ-015 rsv_addr  in  AW  register to reserve.
REQ-016 busy_vec  out  NREGS  scoreboard pending-write bits.
REQ-017 clr_req  in  1  single-cycle pulse that starts a bulk clear.
REQ-018 clr_busy  out  1  high while a bulk clear is in progress.

Function
REQ-019 Reads SHALL be combinational, with zero latency; register 0 SHALL always read all-zero.
REQ-020 A write SHALL commit on the clock edge when wr_en=1, wr_addr!=0 and the FSM is IDLE; only lanes whose wr_mask bit is 1 SHALL change.
REQ-021 Writes to register 0, writes with wr_mask=0, and writes in CLEAR SHALL be dropped with no state change.
REQ-022 With BYPASS=1, a port whose rs_addr equals a committing wr_addr (non-zero, IDLE) SHALL output wr_data on masked lanes and stored data on the other lanes in the same cycle.
REQ-023 With BYPASS=0, reads SHALL return the pre-edge stored value.
REQ-024 A committing write SHALL clear busy_vec[wr_addr] at the edge.
REQ-025 rsv_en in IDLE SHALL set busy_vec[rsv_addr] at the edge; rsv_addr=0 SHALL be ignored.
REQ-026 Simultaneous reserve and write to the same address SHALL leave the bit set (reserve wins).
REQ-027 busy_vec[0] SHALL always be 0.
REQ-028 FSM states: IDLE, CLEAR; IDLE->CLEAR on clr_req; CLEAR->IDLE after the register at index NREGS-1 is zeroed.
REQ-029 On entering CLEAR, the index counter SHALL load 1 and all busy_vec bits SHALL clear.
REQ-030 In CLEAR, each cycle SHALL zero register[counter] and increment the counter, so the whole clear takes NREGS-1 cycles.
REQ-031 clr_busy SHALL equal (state==CLEAR).
REQ-032 In CLEAR, clr_req and rsv_en SHALL be ignored, and reads SHALL return current contents with no bypass.
REQ-033 If clr_req and wr_en occur in the same IDLE cycle, the write SHALL commit and the clear SHALL start that same edge.

Reset
REQ-034 On rst, all registers SHALL be 0, busy_vec SHALL be 0, state SHALL be IDLE, counter SHALL be 0 and clr_busy SHALL be 0, immediately and independent of clk.
REQ-035 rst asserted mid-clear SHALL abort the clear and apply REQ-034.

Structure
REQ-036 Package regfile_pkg SHALL hold the default parameter constants and the state enum (IDLE, CLEAR).
REQ-037 The scoreboard SHALL be a sub-module, reg_scoreboard (set/clear/clear-all, NREGS bits).
REQ-038 Storage SHALL be an array indexed by address; the target is 120-400 lines of RTL.

Verification
REQ-039 Bench SHALL cover: write r5 = {4,3,2,1}, mask 1111, then read r5 on port 2 -> {4,3,2,1}; write r0 = all-ones -> r0 reads 0.
REQ-040 Bench SHALL cover: r3 = {A,B,C,D}, then write {1,1,1,1} with mask 0101 -> r3 = {A,1,C,1}.
REQ-041 Bench SHALL cover: BYPASS=1, write r7 = 0x55 on all lanes while rs_addr[0]=7 -> same-cycle rd_data 0x55; BYPASS=0 -> old value.
REQ-042 Bench SHALL cover: reserve r9 -> busy_vec[9]=1 next cycle; write r9 -> cleared; reserve and write r9 in the same cycle -> stays 1.
REQ-043 Bench SHALL cover: NREGS=16, all registers loaded, clr_req -> clr_busy high for exactly 15 cycles, all registers 0 after, and a write issued during CLEAR is dropped.
REQ-044 Bench SHALL cover: rst asserted at clear cycle 6 -> clr_busy=0 and busy_vec=0 immediately, and all registers 0.
